hook_motion_ctrl: RTL and testbench
===================================

# hook_motion_ctrl

Upstream controller for the hook renderer. Once per video frame it advances the hook's state: it swings the angle back and forth, extends the rope when the player fires, and retracts the rope, slowly if a heavy item was grabbed. After each update it presents a stable `degree`/`length` pair to the hook draw stage, starts one draw with a single-cycle pulse, and waits for that stage's `done` before it accepts the next frame.

## Interface
- `MIN_DEG`, 10: lower swing bound (degrees).
- `MAX_DEG`, 150: upper swing bound.
- `RESET_DEG`, 80: angle after reset.
- `SWING_STEP`, 2: degrees per accepted frame while swinging.
- `MIN_LEN`, 20: rest rope length (pixels).
- `MAX_LEN`, 250: full rope extension.
- `EXTEND_STEP`, 4: length added per frame while extending.
- `RETRACT_FAST`, 4: length removed per frame, empty or light load.
- `RETRACT_SLOW`, 1: length removed per frame, heavy load.
- `clock` in 1: system clock, all logic on the rising edge.
- `reset` in 1: **asynchronous, active-high** reset.
- `frame_tick` in 1: one-cycle pulse per frame.
- `fire` in 1: player fire button, level.
- `hit` in 1: collision with an item, level or pulse.
- `heavy` in 1: the item being hit is heavy; qualifies `hit`.
- `draw_done` in 1: done pulse from the hook draw stage.
- `degree` out 9: hook angle fed to the draw stage.
- `length` out 10: rope length fed to the draw stage.
- `draw_enable` out 1: one-cycle pulse that starts a draw.
- `grabbed` out 1: the hook is carrying an item.
- `catch_done` out 1: one-cycle pulse when a carried item reaches the rest length.
- `missed_frames` out 8: saturating count of dropped frame ticks.

## Operation
Motion FSM, states SWING, EXTEND, RETRACT. It advances only on an **accepted** tick, meaning `frame_tick` arrives while the draw FSM is in D_IDLE.

- **SWING**
  - `length` is held at `MIN_LEN`.
  - `degree` moves by ±`SWING_STEP` according to the direction bit.
  - If the result would pass a bound, `degree` clamps to that bound and the direction bit flips.
  - `fire` high on any cycle in SWING sets `fire_pending`.
  - An accepted tick with `fire_pending` set goes to EXTEND without changing `degree`, and clears `fire_pending`.
- **EXTEND**
  - `degree` is frozen.
  - A cycle with `hit` high sets `hit_pending` and latches `heavy` into `heavy_l`.
  - Accepted tick with `hit_pending` set: `length` is unchanged, `grabbed` goes to 1, state goes to RETRACT.
  - Accepted tick without `hit_pending`:
    - if `length + EXTEND_STEP >= MAX_LEN`: `length` becomes `MAX_LEN`, state goes to RETRACT, `grabbed` stays 0.
    - otherwise `length` increases by `EXTEND_STEP`.
  - If a hit and the maximum length occur on the same tick, the hit wins.
  - `hit_pending` clears on leaving EXTEND.
- **RETRACT**
  - Step size is `RETRACT_SLOW` if `grabbed && heavy_l`, otherwise `RETRACT_FAST`.
  - If `length - step <= MIN_LEN`: `length` becomes `MIN_LEN` and state goes to SWING.
    - `catch_done` pulses if `grabbed` was 1.
    - `grabbed` and `heavy_l` clear.
    - The swing direction is kept.
  - `fire` and `hit` are ignored in RETRACT.
- **Arithmetic**: comparisons use 11-bit unsigned intermediates, so no wrap-around occurs. Clamping is the only saturation.
- **Draw FSM**, states D_IDLE, D_WAIT:
  - D_IDLE to D_WAIT on an accepted tick.
  - D_WAIT to D_IDLE on `draw_done`.
  - `degree` and `length` change only on accepted ticks, so they are constant from `draw_enable` until `draw_done`.
- **Dropped ticks**: a `frame_tick` in D_WAIT, including one in the same cycle as `draw_done`, is dropped and `missed_frames` increments, saturating at 255.

## Timing
- Reset values:
  - `degree` = `RESET_DEG`, direction = increasing, `length` = `MIN_LEN`.
  - `draw_enable`, `grabbed`, `catch_done`, `missed_frames` = 0.
  - `fire_pending`, `hit_pending`, `heavy_l` = 0.
  - Motion FSM in SWING, draw FSM in D_IDLE.
- Accepted tick in cycle T:
  - Updated `degree`, `length`, `grabbed` and the new state are visible in T+1.
  - `draw_enable` is high in T+1 only.
  - The draw FSM is in D_WAIT from T+1.
- `catch_done` is high in T+1 of the tick that finishes the retract.
- `draw_done` in cycle D puts the draw FSM in D_IDLE at D+1. A tick in D+1 is accepted.
- Reset asserted mid-draw or mid-extend returns every output to its reset value immediately. Any `draw_done` arriving after reset deasserts while in D_IDLE is ignored.

## Structure
- Package `gm_hook_pkg` holds:
  - the motion-state and draw-state enums;
  - default parameter constants;
  - 9/10-bit width localparams shared with the draw stage.
- One sub-module, `hook_draw_handshake`:
  - contains the draw FSM, the `draw_enable` generation and the `missed_frames` counter;
  - outputs an `accept` strobe that gates the motion update.

## Test plan
- **Reset then swing**: reset, then 35 accepted ticks give `degree` 150. Tick 36 gives 148 (direction reversed). `length` stays 20 throughout.
- **Extend to maximum**: pulse `fire`, then one tick enters EXTEND. After 57 ticks `length` is 248. Tick 58 gives `length` 250 and state RETRACT with `grabbed` 0. Fast retract then takes 58 ticks: 22, then clamp to 20, back to SWING, no `catch_done`.
- **Heavy catch**: extend to `length` 100, assert `hit` and `heavy` for one cycle. Next tick: RETRACT, `grabbed` 1, `length` 100. After 80 ticks: `length` 20, `catch_done` pulses once, `grabbed` 0.
- **Hit wins over maximum**: `length` 248 with `hit_pending` set. Next tick: `length` 248, `grabbed` 1.
- **Handshake**: hold `draw_done` low and send 3 ticks. Expect one `draw_enable`, `missed_frames` 2, `degree` unchanged. `draw_done` and a tick in the same cycle: `missed_frames` 3. A tick the following cycle is accepted.
- **Reset mid-operation**: assert `reset` in EXTEND at `length` 60 during D_WAIT. Outputs return to their reset values in the same cycle. After release, a stray `draw_done` causes no change.

Source files
------------

// File: rtl/gm_hook_pkg.sv
// Shared types and constants for the hook motion controller and its draw stage.
package gm_hook_pkg;

    localparam int DEG_W   = 9;
    localparam int LEN_W   = 10;
    localparam int ARITH_W = 11;
    localparam int MISS_W  = 8;

    localparam int DEF_MIN_DEG      = 10;
    localparam int DEF_MAX_DEG      = 150;
    localparam int DEF_RESET_DEG    = 80;
    localparam int DEF_SWING_STEP   = 2;
    localparam int DEF_MIN_LEN      = 20;
    localparam int DEF_MAX_LEN      = 250;
    localparam int DEF_EXTEND_STEP  = 4;
    localparam int DEF_RETRACT_FAST = 4;
    localparam int DEF_RETRACT_SLOW = 1;

    typedef enum logic [1:0] {
        SWING   = 2'd0,
        EXTEND  = 2'd1,
        RETRACT = 2'd2
    } motion_state_t;

    typedef enum logic {
        D_IDLE = 1'b0,
        D_WAIT = 1'b1
    } draw_state_t;

endpackage

// File: rtl/hook_draw_handshake.sv
// Draw-stage handshake: accepts one frame tick per draw, pulses draw_enable
// and counts ticks dropped while a draw is outstanding.
module hook_draw_handshake
    import gm_hook_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              frame_tick,
    input  logic              draw_done,
    output logic              accept,
    output logic              draw_enable,
    output logic [MISS_W-1:0] missed_frames
);

    draw_state_t state, state_n;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        case (state)
            D_IDLE: begin
                if (frame_tick) begin
                    accept  = 1'b1;
                    state_n = D_WAIT;
                end
            end
            D_WAIT: begin
                if (draw_done) state_n = D_IDLE;
            end
            default: state_n = D_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= D_IDLE;
            draw_enable   <= 1'b0;
            missed_frames <= '0;
        end else begin
            state       <= state_n;
            draw_enable <= accept;
            // A tick coinciding with draw_done is still dropped: the stage was busy that cycle.
            if (frame_tick && state == D_WAIT && missed_frames != {MISS_W{1'b1}})
                missed_frames <= missed_frames + 1'b1;
        end
    end

endmodule

// File: rtl/hook_motion_ctrl.sv
// Per-frame hook motion: swing, extend on fire, retract (slowly when a heavy
// item is carried), with one draw handshake per accepted frame.
module hook_motion_ctrl
    import gm_hook_pkg::*;
#(
    parameter int MIN_DEG      = DEF_MIN_DEG,
    parameter int MAX_DEG      = DEF_MAX_DEG,
    parameter int RESET_DEG    = DEF_RESET_DEG,
    parameter int SWING_STEP   = DEF_SWING_STEP,
    parameter int MIN_LEN      = DEF_MIN_LEN,
    parameter int MAX_LEN      = DEF_MAX_LEN,
    parameter int EXTEND_STEP  = DEF_EXTEND_STEP,
    parameter int RETRACT_FAST = DEF_RETRACT_FAST,
    parameter int RETRACT_SLOW = DEF_RETRACT_SLOW
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              frame_tick,
    input  logic              fire,
    input  logic              hit,
    input  logic              heavy,
    input  logic              draw_done,
    output logic [DEG_W-1:0]  degree,
    output logic [LEN_W-1:0]  length,
    output logic              draw_enable,
    output logic              grabbed,
    output logic              catch_done,
    output logic [MISS_W-1:0] missed_frames
);

    localparam logic [ARITH_W-1:0] MIN_DEG_A   = ARITH_W'(MIN_DEG);
    localparam logic [ARITH_W-1:0] MAX_DEG_A   = ARITH_W'(MAX_DEG);
    localparam logic [ARITH_W-1:0] SWING_A     = ARITH_W'(SWING_STEP);
    localparam logic [ARITH_W-1:0] MIN_LEN_A   = ARITH_W'(MIN_LEN);
    localparam logic [ARITH_W-1:0] MAX_LEN_A   = ARITH_W'(MAX_LEN);
    localparam logic [ARITH_W-1:0] EXTEND_A    = ARITH_W'(EXTEND_STEP);
    localparam logic [ARITH_W-1:0] RET_FAST_A  = ARITH_W'(RETRACT_FAST);
    localparam logic [ARITH_W-1:0] RET_SLOW_A  = ARITH_W'(RETRACT_SLOW);

    motion_state_t    state, state_n;
    logic [DEG_W-1:0] degree_n;
    logic [LEN_W-1:0] length_n;
    logic             dir, dir_n;
    logic             grabbed_n, catch_n;
    logic             heavy_l, heavy_n;
    logic             fire_pending, fire_n;
    logic             hit_pending, hit_n;
    logic             accept;

    logic [ARITH_W-1:0] deg_a, len_a, ret_step;

    hook_draw_handshake u_handshake (
        .clock         (clock),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .draw_done     (draw_done),
        .accept        (accept),
        .draw_enable   (draw_enable),
        .missed_frames (missed_frames)
    );

    assign deg_a    = ARITH_W'(degree);
    assign len_a    = ARITH_W'(length);
    assign ret_step = (grabbed && heavy_l) ? RET_SLOW_A : RET_FAST_A;

    always_comb begin
        state_n   = state;
        degree_n  = degree;
        length_n  = length;
        dir_n     = dir;
        grabbed_n = grabbed;
        heavy_n   = heavy_l;
        fire_n    = fire_pending;
        hit_n     = hit_pending;
        catch_n   = 1'b0;
        case (state)
            SWING: begin
                length_n = LEN_W'(MIN_LEN_A);
                if (accept && fire_pending) begin
                    state_n = EXTEND;
                    fire_n  = 1'b0;
                end else begin
                    if (fire) fire_n = 1'b1;
                    if (accept) begin
                        // Reaching a bound counts as hitting it: clamp and reverse.
                        if (dir) begin
                            if (deg_a + SWING_A >= MAX_DEG_A) begin
                                degree_n = DEG_W'(MAX_DEG_A);
                                dir_n    = 1'b0;
                            end else begin
                                degree_n = DEG_W'(deg_a + SWING_A);
                            end
                        end else begin
                            if (deg_a <= MIN_DEG_A + SWING_A) begin
                                degree_n = DEG_W'(MIN_DEG_A);
                                dir_n    = 1'b1;
                            end else begin
                                degree_n = DEG_W'(deg_a - SWING_A);
                            end
                        end
                    end
                end
            end
            EXTEND: begin
                if (hit) begin
                    hit_n   = 1'b1;
                    heavy_n = heavy;
                end
                if (accept) begin
                    if (hit_pending) begin
                        grabbed_n = 1'b1;
                        state_n   = RETRACT;
                        hit_n     = 1'b0;
                    end else if (len_a + EXTEND_A >= MAX_LEN_A) begin
                        length_n = LEN_W'(MAX_LEN_A);
                        state_n  = RETRACT;
                        hit_n    = 1'b0;
                    end else begin
                        length_n = LEN_W'(len_a + EXTEND_A);
                    end
                end
            end
            RETRACT: begin
                if (accept) begin
                    if (len_a <= MIN_LEN_A + ret_step) begin
                        length_n  = LEN_W'(MIN_LEN_A);
                        state_n   = SWING;
                        catch_n   = grabbed;
                        grabbed_n = 1'b0;
                        heavy_n   = 1'b0;
                    end else begin
                        length_n = LEN_W'(len_a - ret_step);
                    end
                end
            end
            default: state_n = SWING;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= SWING;
            degree       <= DEG_W'(RESET_DEG);
            length       <= LEN_W'(MIN_LEN);
            dir          <= 1'b1;
            grabbed      <= 1'b0;
            heavy_l      <= 1'b0;
            fire_pending <= 1'b0;
            hit_pending  <= 1'b0;
            catch_done   <= 1'b0;
        end else begin
            state        <= state_n;
            degree       <= degree_n;
            length       <= length_n;
            dir          <= dir_n;
            grabbed      <= grabbed_n;
            heavy_l      <= heavy_n;
            fire_pending <= fire_n;
            hit_pending  <= hit_n;
            catch_done   <= catch_n;
        end
    end

endmodule

// File: tb/tb_hook_motion_ctrl.sv
// Self-checking bench for hook_motion_ctrl: table-driven motion rows, a
// scoreboard checked on every draw_enable, plus handshake and reset sequences.
module tb_hook_motion_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       fire = 1'b0;
    logic       hit = 1'b0;
    logic       heavy = 1'b0;
    logic       draw_done = 1'b0;
    logic [8:0] degree;
    logic [9:0] length;
    logic       draw_enable;
    logic       grabbed;
    logic       catch_done;
    logic [7:0] missed_frames;

    int checks = 0;
    int failures = 0;
    int cd_count = 0;

    hook_motion_ctrl dut (
        .clock         (clock),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .fire          (fire),
        .hit           (hit),
        .heavy         (heavy),
        .draw_done     (draw_done),
        .degree        (degree),
        .length        (length),
        .draw_enable   (draw_enable),
        .grabbed       (grabbed),
        .catch_done    (catch_done),
        .missed_frames (missed_frames)
    );

    always #5 clock = ~clock;

    typedef struct {
        int deg;
        int len;
        bit grab;
        bit cd;
    } exp_t;

    typedef struct {
        bit fire;
        bit hit;
        bit heavy;
        int n;
        int deg;
        int len;
        bit grab;
        int cd;
    } row_t;

    exp_t sb[$];

    // Reference model state (0 swing, 1 extend, 2 retract)
    int m_state, m_deg, m_len, m_missed;
    bit m_dir, m_grab, m_heavy, m_fire, m_hit, m_busy;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_deg = 80; m_len = 20; m_dir = 1'b1; m_grab = 1'b0;
        m_heavy = 1'b0; m_fire = 1'b0; m_hit = 1'b0; m_busy = 1'b0; m_missed = 0;
    endtask

    task automatic model_step();
        exp_t e;
        int step;
        bit cd;
        cd = 1'b0;
        if (m_state == 0) begin
            if (m_fire) begin
                m_state = 1;
                m_fire = 1'b0;
            end else if (m_dir) begin
                if (m_deg + 2 >= 150) begin m_deg = 150; m_dir = 1'b0; end
                else m_deg = m_deg + 2;
            end else begin
                if (m_deg - 2 <= 10) begin m_deg = 10; m_dir = 1'b1; end
                else m_deg = m_deg - 2;
            end
        end else if (m_state == 1) begin
            if (m_hit) begin
                m_grab = 1'b1; m_state = 2; m_hit = 1'b0;
            end else if (m_len + 4 >= 250) begin
                m_len = 250; m_state = 2; m_hit = 1'b0;
            end else begin
                m_len = m_len + 4;
            end
        end else begin
            step = (m_grab && m_heavy) ? 1 : 4;
            if (m_len - step <= 20) begin
                m_len = 20; m_state = 0; cd = m_grab; m_grab = 1'b0; m_heavy = 1'b0;
            end else begin
                m_len = m_len - step;
            end
        end
        e.deg = m_deg; e.len = m_len; e.grab = m_grab; e.cd = cd;
        sb.push_back(e);
    endtask

    // One frame tick; optionally answer it with a draw_done two cycles later.
    task automatic tick(input bit respond);
        frame_tick = 1'b1;
        @(posedge clock); #1;
        frame_tick = 1'b0;
        if (m_busy) begin
            if (m_missed < 255) m_missed++;
        end else begin
            model_step();
            m_busy = 1'b1;
        end
        if (respond) begin
            @(posedge clock); #1;
            draw_done = 1'b1;
            @(posedge clock); #1;
            draw_done = 1'b0;
            m_busy = 1'b0;
        end
    endtask

    task automatic pulse_fire();
        fire = 1'b1;
        @(posedge clock); #1;
        fire = 1'b0;
        if (m_state == 0) m_fire = 1'b1;
    endtask

    task automatic pulse_hit(input bit hv);
        hit = 1'b1; heavy = hv;
        @(posedge clock); #1;
        hit = 1'b0; heavy = 1'b0;
        if (m_state == 1) begin m_hit = 1'b1; m_heavy = hv; end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_degree"}, degree, 80);
        check({tag, "_length"}, length, 20);
        check({tag, "_draw_enable"}, draw_enable, 0);
        check({tag, "_grabbed"}, grabbed, 0);
        check({tag, "_catch_done"}, catch_done, 0);
        check({tag, "_missed"}, missed_frames, 0);
    endtask

    // Scoreboard: every draw_enable pops and compares the expected motion result.
    always @(negedge clock) begin
        if (!reset) begin
            if (draw_enable) begin
                if (sb.size() == 0) begin
                    check("unexpected_draw_enable", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_degree", degree, e.deg);
                    check("sb_length", length, e.len);
                    check("sb_grabbed", grabbed, e.grab);
                    check("sb_catch_done", catch_done, e.cd);
                end
            end else if (catch_done) begin
                check("stray_catch_done", 1, 0);
            end
            if (catch_done) cd_count++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        row_t rows[18];
        int cd_before;

        rows[0]  = '{0, 0, 0, 35, 150,  20, 0, 0};
        rows[1]  = '{0, 0, 0,  1, 148,  20, 0, 0};
        rows[2]  = '{1, 0, 0,  1, 148,  20, 0, 0};
        rows[3]  = '{0, 0, 0, 57, 148, 248, 0, 0};
        rows[4]  = '{0, 0, 0,  1, 148, 250, 0, 0};
        rows[5]  = '{0, 0, 0, 57, 148,  22, 0, 0};
        rows[6]  = '{0, 0, 0,  1, 148,  20, 0, 0};
        rows[7]  = '{1, 0, 0,  1, 148,  20, 0, 0};
        rows[8]  = '{0, 0, 0, 20, 148, 100, 0, 0};
        rows[9]  = '{0, 1, 1,  1, 148, 100, 1, 0};
        rows[10] = '{0, 0, 0, 79, 148,  21, 1, 0};
        rows[11] = '{0, 0, 0,  1, 148,  20, 0, 1};
        rows[12] = '{1, 0, 0,  1, 148,  20, 0, 0};
        rows[13] = '{0, 0, 0, 57, 148, 248, 0, 0};
        rows[14] = '{0, 1, 0,  1, 148, 248, 1, 0};
        rows[15] = '{0, 0, 0, 56, 148,  24, 1, 0};
        rows[16] = '{0, 0, 0,  1, 148,  20, 0, 1};
        rows[17] = '{0, 0, 0,  1, 146,  20, 0, 0};

        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_reset_values("in_reset");
        reset = 1'b0;
        @(posedge clock); #1;
        check_reset_values("after_reset");

        for (int r = 0; r < 18; r++) begin
            cd_before = cd_count;
            if (rows[r].fire) pulse_fire();
            if (rows[r].hit) pulse_hit(rows[r].heavy);
            for (int t = 0; t < rows[r].n; t++) tick(1'b1);
            check($sformatf("row%0d_degree", r), degree, rows[r].deg);
            check($sformatf("row%0d_length", r), length, rows[r].len);
            check($sformatf("row%0d_grabbed", r), grabbed, rows[r].grab);
            check($sformatf("row%0d_catch_count", r), cd_count - cd_before, rows[r].cd);
        end

        // Handshake: one accepted tick, two dropped while the draw is outstanding.
        tick(1'b0);
        tick(1'b0);
        tick(1'b0);
        check("hs_missed_2", missed_frames, 2);
        check("hs_degree_held", degree, 144);
        check("hs_model_missed", missed_frames, m_missed);
        frame_tick = 1'b1; draw_done = 1'b1;
        @(posedge clock); #1;
        frame_tick = 1'b0; draw_done = 1'b0;
        m_missed++;
        m_busy = 1'b0;
        check("hs_missed_3", missed_frames, 3);
        tick(1'b1);
        check("hs_accept_after_done", degree, 142);
        check("hs_missed_still_3", missed_frames, 3);

        // Reset mid-extend while a draw is outstanding.
        pulse_fire();
        tick(1'b1);
        for (int t = 0; t < 9; t++) tick(1'b1);
        check("rst_pre_length", length, 56);
        tick(1'b0);
        @(posedge clock); #1;
        check("rst_pre_length60", length, 60);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("mid_reset");
        model_reset();
        @(posedge clock); #1;
        reset = 1'b0;
        draw_done = 1'b1;
        @(posedge clock); #1;
        draw_done = 1'b0;
        @(posedge clock); #1;
        check_reset_values("stray_done");
        tick(1'b1);
        check("post_reset_swing", degree, 82);
        check("post_reset_length", length, 20);

        repeat (3) @(posedge clock);
        #1;
        check("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
